// File: rtl/serial_word_shifter.sv
// serial_word_shifter
//   Takes parallel words over a valid/ready handshake and sends them one bit
//   per clock on ser_out, qualified by ser_valid. A one-word hold buffer lets
//   the next word follow the current one with no idle bit in between.
//
//   Ports
//     clk        clock, rising edge
//     rst        asynchronous, active-high reset
//     din        parallel word to serialise
//     din_valid  din holds a word
//     din_ready  a word can be accepted this cycle (registered only)
//     abort      synchronous discard of the word in flight and the held word
//     ser_out    serial bit (IDLE_BIT when ser_valid = 0)
//     ser_valid  ser_out carries a data bit
//     last       ser_out carries the final bit of a word
//     bit_idx    position of the current bit, 0 = first bit sent
//     busy       shifting, or the hold buffer is full
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | nothing on the serial line
//   S_SHIFT | sreg_q is being sent, bit_idx_q is the current bit
module serial_word_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     abort,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic                     last,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;

  logic accept;
  logic last_bit;
  logic shifter_free;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;

    accept       = din_valid & ~hold_full_q;
    last_bit     = (state_q == S_SHIFT) && (bit_idx_q == LAST_IDX);
    // Free means the accepted word can go straight into sreg this edge.
    shifter_free = (state_q == S_IDLE) | (last_bit & ~hold_full_q);

    if (abort) begin
      // Drops the word in flight, the held word and anything offered now.
      state_d     = S_IDLE;
      hold_full_d = 1'b0;
      bit_idx_d   = '0;
    end else begin
      if (state_q == S_SHIFT) begin
        if (last_bit) begin
          bit_idx_d = '0;
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_idx_d = bit_idx_q + IW'(1);
          if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
        end
      end

      // accept implies the hold is empty, so it never collides with a drain.
      if (accept) begin
        if (shifter_free) begin
          sreg_d    = din;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end else begin
          hold_d      = din;
          hold_full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

  // All outputs come from flops only, so reset reaches them immediately.
  assign ser_valid = (state_q == S_SHIFT);
  assign ser_out   = ser_valid ? (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]) : IDLE_BIT;
  assign last      = ser_valid & (bit_idx_q == LAST_IDX);
  assign bit_idx   = bit_idx_q;
  assign busy      = ser_valid | hold_full_q;
  assign din_ready = ~hold_full_q;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter. The reference is a queue of pending serial
// bits: an accepted word appends its WIDTH bits, every edge with data pops
// one, abort/reset empty it. A word can be taken while at most WIDTH bits are
// still pending (i.e. at most the word in flight, no held word).
module tb_serial_word_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid, abort;
  logic         din_ready, ser_out, ser_valid, last, busy;
  logic [2:0]   bit_idx;

  logic [W-1:0] din_l;
  logic         din_valid_l;
  logic         din_ready_l, ser_out_l, ser_valid_l, last_l, busy_l;
  logic [2:0]   bit_idx_l;

  always #5 clk = ~clk;

  serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .abort(abort), .ser_out(ser_out), .ser_valid(ser_valid), .last(last),
    .bit_idx(bit_idx), .busy(busy)
  );

  serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .abort(1'b0), .ser_out(ser_out_l), .ser_valid(ser_valid_l), .last(last_l),
    .bit_idx(bit_idx_l), .busy(busy_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic b; int idx; } sbit_t;
  sbit_t mq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      bit can_take;
      can_take = (mq.size() <= W);
      if (abort) begin
        mq.delete();
      end else begin
        if (mq.size() > 0) void'(mq.pop_front());
        if (din_valid && can_take)
          for (int i = 0; i < W; i++) begin
            sbit_t e;
            e.b   = din[W-1-i];
            e.idx = i;
            mq.push_back(e);
          end
      end
    end
  end

  // ---------------- compare + serial log ----------------
  bit          chk_en = 1'b0;
  logic [63:0] log_bits;
  int          log_n, log_last;
  logic [7:0]  lsb_bits;
  int          lsb_n;

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_v;
      exp_v = (mq.size() > 0);
      chk("ser_valid", ser_valid, exp_v);
      chk("busy", busy, exp_v);
      chk("din_ready", din_ready, mq.size() <= W);
      if (exp_v) begin
        chk("ser_out", ser_out, mq[0].b);
        chk("bit_idx", bit_idx, mq[0].idx);
        chk("last", last, mq[0].idx == W-1);
      end else begin
        chk("ser_out_idle", ser_out, 0);
        chk("last_idle", last, 0);
      end
    end
    if (ser_valid) begin
      log_bits = {log_bits[62:0], ser_out};
      log_n++;
      if (last) log_last++;
    end
    if (ser_valid_l) begin
      lsb_bits = {lsb_bits[6:0], ser_out_l};
      lsb_n++;
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input logic [W-1:0] w);
    din = w;
    din_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (din_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100; t++) begin
      if (!busy) return;
      @(negedge clk);
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_idx(input int k);
    for (int t = 0; t < 40; t++) begin
      if (ser_valid && bit_idx == k) return;
      @(negedge clk);
    end
    chk("idx_timeout", 1, 0);
  endtask

  task automatic clear_log();
    log_bits = '0;
    log_n    = 0;
    log_last = 0;
  endtask

  int det;

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; abort = 1'b0;
    din_l = '0; din_valid_l = 1'b0;
    clear_log();
    lsb_bits = '0; lsb_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", din_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_idx", bit_idx, 0);
    chk("rst_ser_out", ser_out, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // single word
    clear_log();
    send(8'hDA);
    din_valid = 1'b0;
    wait_idle();
    chk("single_bits", log_bits[7:0], 8'hDA);
    chk("single_n", log_n, 8);
    chk("single_last", log_last, 1);

    // back-to-back, zero gap enforced cycle by cycle by the model
    clear_log();
    send(8'hDB);
    send(8'h6D);
    chk("b2b_ready_drop", din_ready, 0);
    din_valid = 1'b0;
    wait_idle();
    chk("b2b_bits", log_bits[15:0], 16'hDB6D);
    chk("b2b_n", log_n, 16);
    chk("b2b_last", log_last, 2);
    det = 0;
    for (int i = 0; i <= 12; i++)
      if (log_bits[15-i -: 4] == 4'b1101) det++;
    chk("b2b_1101_hits", det, 5);

    // backpressure
    clear_log();
    send(8'hA5);
    send(8'h3C);
    chk("bp_ready_low", din_ready, 0);
    send(8'hF0);
    din_valid = 1'b0;
    wait_idle();
    chk("bp_bits", log_bits[23:0], 24'hA53CF0);
    chk("bp_n", log_n, 24);

    // LSB-first instance
    din_l = 8'h0B;
    din_valid_l = 1'b1;
    @(negedge clk);
    din_valid_l = 1'b0;
    repeat (10) @(negedge clk);
    chk("lsb_bits", lsb_bits, 8'hD0);
    chk("lsb_n", lsb_n, 8);

    // abort with a word held
    clear_log();
    send(8'hFF);
    send(8'h0F);
    din_valid = 1'b0;
    wait_idx(3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", ser_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", din_ready, 1);
    repeat (10) @(negedge clk);
    chk("abort_n", log_n, 4);
    chk("abort_bits", log_bits[3:0], 4'hF);

    // asynchronous reset mid-word
    send(8'hC3);
    din_valid = 1'b0;
    wait_idx(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ser_valid, 0);
    chk("arst_last", last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ser_out", ser_out, 0);
    chk("arst_ready", din_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    send(8'h81);
    din_valid = 1'b0;
    wait_idle();
    chk("arst_new_bits", log_bits[7:0], 8'h81);
    chk("arst_new_n", log_n, 8);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 600; c++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 50) == 0);
      @(negedge clk);
    end
    din_valid = 1'b0;
    abort = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
